// File: rtl/cn_minsum_serial_if.sv
// Message bus for the serial check-node processor.
//
// Handshake: a beat moves on a channel in the cycle where both valid and
// ready are high at the rising clock edge. A source holds valid and its data
// stable until the beat is accepted. A sink may raise or lower ready at any
// time. Valid never depends on ready.
//
// Signals:
//   in_valid / in_ready / in_msg          variable-to-check messages into the block
//   out_valid / out_ready / out_msg       check-to-variable messages out of the block
//   out_last                              marks the final beat of a row
//   state_dbg                             FSM state for observation (1 = emitting)
// Modports:
//   master : upstream/downstream side (drives in_*, out_ready)
//   slave  : the check-node processor
interface cn_minsum_serial_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_msg;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_msg;
    logic                  out_last;
    logic                  state_dbg;

    modport master (
        output in_valid, in_msg, out_ready,
        input  in_ready, out_valid, out_msg, out_last, state_dbg
    );

    modport slave (
        input  in_valid, in_msg, out_ready,
        output in_ready, out_valid, out_msg, out_last, state_dbg
    );
endinterface

// File: rtl/cn_minsum_serial.sv
// Serial offset-min-sum check-node processor for the LDPC QKD decoder.
//
// Accepts DEG variable-to-check messages (one edge per beat) for one parity
// check row, tracking the two smallest magnitudes, the position of the
// smallest, each edge's sign and the running sign parity. It then emits DEG
// check-to-variable messages in the same edge order. Rows never overlap:
// the block accepts input only while accumulating and emits only afterwards.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    cn_minsum_serial_if.slave (in_valid/in_ready/in_msg,
//          out_valid/out_ready/out_msg/out_last, state_dbg)
module cn_minsum_serial #(
    parameter int DATA_WIDTH = 16,
    parameter int INT        = 8,
    parameter int FRAC       = 8,
    parameter int DEG        = 6,
    parameter int OFFSET     = 0
) (
    input logic               clk,
    input logic               rst_n,
    cn_minsum_serial_if.slave bus
);
    // Magnitude width: the message format minus its sign bit.
    localparam int              MW        = INT + FRAC - 1;
    localparam int              CW        = $clog2(DEG);
    localparam logic [MW-1:0]   MAG_MAX   = {MW{1'b1}};
    localparam logic [MW-1:0]   OFF       = MW'(OFFSET);
    localparam logic [CW-1:0]   LAST_EDGE = CW'(DEG - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]  in_cnt;
    logic [CW-1:0]  out_cnt;
    logic [MW-1:0]  min1;
    logic [MW-1:0]  min2;
    logic [CW-1:0]  idx;
    logic           sign_tot;
    logic [DEG-1:0] signs;

    logic in_fire, out_fire, row_in_done, row_out_done;

    assign in_fire      = bus.in_valid && (state == ACCUM);
    assign out_fire     = bus.out_ready && (state == EMIT);
    assign row_in_done  = in_fire && (in_cnt == LAST_EDGE);
    assign row_out_done = out_fire && (out_cnt == LAST_EDGE);

    // Saturated magnitude: the most negative code has no positive twin, so
    // its negation wraps back to a negative value and is clamped instead.
    logic [DATA_WIDTH-1:0] neg_msg;
    logic [MW-1:0]         mag;

    always_comb begin
        neg_msg = -bus.in_msg;
        if (!bus.in_msg[DATA_WIDTH-1]) begin
            mag = bus.in_msg[MW-1:0];
        end else if (neg_msg[DATA_WIDTH-1]) begin
            mag = MAG_MAX;
        end else begin
            mag = neg_msg[MW-1:0];
        end
    end

    // The first beat of a row compares against the reset values rather than
    // whatever the previous row left behind.
    logic          first_beat;
    logic [MW-1:0] base1, base2;
    logic [CW-1:0] base_idx;
    logic          base_tot;

    assign first_beat = (in_cnt == '0);
    assign base1      = first_beat ? MAG_MAX : min1;
    assign base2      = first_beat ? MAG_MAX : min2;
    assign base_idx   = first_beat ? '0 : idx;
    assign base_tot   = first_beat ? 1'b0 : sign_tot;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (row_in_done)  state_nxt = EMIT;
            EMIT:    if (row_out_done) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // Accumulator and edge counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt   <= '0;
            out_cnt  <= '0;
            min1     <= MAG_MAX;
            min2     <= MAG_MAX;
            idx      <= '0;
            sign_tot <= 1'b0;
            signs    <= '0;
        end else begin
            if (in_fire) begin
                signs[in_cnt] <= bus.in_msg[DATA_WIDTH-1];
                sign_tot      <= base_tot ^ bus.in_msg[DATA_WIDTH-1];
                // Strict compares: on a tie the earlier edge keeps idx.
                if (mag < base1) begin
                    min2 <= base1;
                    min1 <= mag;
                    idx  <= in_cnt;
                end else begin
                    min1 <= base1;
                    min2 <= (mag < base2) ? mag : base2;
                    idx  <= base_idx;
                end
                in_cnt <= row_in_done ? '0 : in_cnt + 1'b1;
            end
            if (out_fire) begin
                out_cnt <= row_out_done ? '0 : out_cnt + 1'b1;
            end
            if (row_out_done) begin
                min1     <= MAG_MAX;
                min2     <= MAG_MAX;
                idx      <= '0;
                sign_tot <= 1'b0;
            end
        end
    end

    // Output logic: everything below is a function of registered state, so
    // out_msg/out_last hold steady while the sink stalls.
    logic [MW-1:0] m_sel;
    logic [MW-1:0] m_off;
    logic          s_out;

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_msg   = '0;
        bus.out_last  = 1'b0;
        // Excluding the edge itself: the smallest magnitude from the others.
        m_sel = (out_cnt == idx) ? min2 : min1;
        m_off = (m_sel > OFF) ? (m_sel - OFF) : '0;
        s_out = sign_tot ^ signs[out_cnt];
        case (state)
            ACCUM: begin
                bus.in_ready = 1'b1;
            end
            EMIT: begin
                bus.out_valid = 1'b1;
                bus.out_msg   = s_out ? -{1'b0, m_off} : {1'b0, m_off};
                bus.out_last  = (out_cnt == LAST_EDGE);
            end
            default: begin
                bus.in_ready = 1'b0;
            end
        endcase
    end

    assign bus.state_dbg = (state == EMIT);
endmodule

// File: tb/tb_cn_minsum_serial.sv
// Testbench for cn_minsum_serial. Two instances (OFFSET 0 and OFFSET 0x40)
// share the same stimulus; a min-sum model computes every expected output
// beat from the accepted input row, and fixed tables pin the model.
module tb_cn_minsum_serial;
    localparam int W    = 16;
    localparam int DEG  = 6;
    localparam int OFF1 = 'h40;

    localparam logic [W-1:0] ROW1 [DEG] = '{16'h0200, 16'hFF00, 16'h0080, 16'h0300, 16'hFE00, 16'h0100};
    localparam logic [W-1:0] E1_0 [DEG] = '{16'h0080, 16'hFF80, 16'h0100, 16'h0080, 16'hFF80, 16'h0080};
    localparam logic [W-1:0] E1_1 [DEG] = '{16'h0040, 16'hFFC0, 16'h00C0, 16'h0040, 16'hFFC0, 16'h0040};
    localparam logic [W-1:0] ROW2 [DEG] = '{16'h0020, 16'h0300, 16'hFF00, 16'h0200, 16'h0400, 16'h0100};
    localparam logic [W-1:0] E2_0 [DEG] = '{16'hFF00, 16'hFFE0, 16'h0020, 16'hFFE0, 16'hFFE0, 16'hFFE0};
    localparam logic [W-1:0] E2_1 [DEG] = '{16'hFF40, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    localparam logic [W-1:0] ROWS [DEG] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
    localparam logic [W-1:0] ES_0 [DEG] = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001};
    localparam logic [W-1:0] ES_1 [DEG] = '{16'h8041, 16'h8041, 16'h8041, 16'h8041, 16'h8041, 16'h8041};
    localparam logic [W-1:0] ROWT [DEG] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100};
    localparam logic [W-1:0] ET_0 [DEG] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100};
    localparam logic [W-1:0] ET_1 [DEG] = '{16'h00C0, 16'h00C0, 16'h00C0, 16'h00C0, 16'h00C0, 16'h00C0};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0;
    logic [W-1:0] in_msg = '0;
    logic         out_ready = 1'b1;

    cn_minsum_serial_if #(.DATA_WIDTH(W)) if0 ();
    cn_minsum_serial_if #(.DATA_WIDTH(W)) if1 ();

    assign if0.in_valid  = in_valid;
    assign if0.in_msg    = in_msg;
    assign if0.out_ready = out_ready;
    assign if1.in_valid  = in_valid;
    assign if1.in_msg    = in_msg;
    assign if1.out_ready = out_ready;

    cn_minsum_serial #(.DATA_WIDTH(W), .INT(8), .FRAC(8), .DEG(DEG), .OFFSET(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );
    cn_minsum_serial #(.DATA_WIDTH(W), .INT(8), .FRAC(8), .DEG(DEG), .OFFSET(OFF1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [W:0]   exp_q0[$];
    logic [W:0]   exp_q1[$];
    logic [W:0]   cap0[$];
    logic [W:0]   cap1[$];
    logic [W-1:0] row_q[$];
    logic [W-1:0] row_a [DEG];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Min-sum by definition: for edge j, the smallest saturated magnitude
    // among all other edges, signed by the parity of the other edges' signs.
    function automatic logic [W-1:0] cn_expect(input logic [W-1:0] row [DEG], input int j, input int off);
        int best, sgn, v, a, m;
        best = 32767;
        sgn  = 0;
        for (int k = 0; k < DEG; k++) begin
            if (k != j) begin
                v = int'($signed(row[k]));
                a = (v < 0) ? -v : v;
                if (a > 32767) a = 32767;
                if (a < best) best = a;
                if (v < 0) sgn ^= 1;
            end
        end
        m = (best > off) ? best - off : 0;
        return (sgn != 0) ? W'(-m) : W'(m);
    endfunction

    // Compare process: checks both DUTs every cycle they are out of reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            row_q.delete();
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            chk("out_valid0", if0.out_valid, exp_q0.size() != 0);
            chk("out_valid1", if1.out_valid, exp_q1.size() != 0);
            chk("in_ready0", if0.in_ready, exp_q0.size() == 0);
            chk("in_ready1", if1.in_ready, exp_q1.size() == 0);
            chk("state_dbg0", if0.state_dbg, exp_q0.size() != 0);
            if (if0.out_valid && exp_q0.size() != 0) begin
                chk("beat0", {if0.out_last, if0.out_msg}, exp_q0[0]);
                if (out_ready) begin
                    void'(exp_q0.pop_front());
                    cap0.push_back({if0.out_last, if0.out_msg});
                end
            end
            if (if1.out_valid && exp_q1.size() != 0) begin
                chk("beat1", {if1.out_last, if1.out_msg}, exp_q1[0]);
                if (out_ready) begin
                    void'(exp_q1.pop_front());
                    cap1.push_back({if1.out_last, if1.out_msg});
                end
            end
            if (in_valid && if0.in_ready) begin
                row_q.push_back(in_msg);
                if (row_q.size() == DEG) begin
                    for (int k = 0; k < DEG; k++) row_a[k] = row_q[k];
                    for (int j = 0; j < DEG; j++) begin
                        exp_q0.push_back({(j == DEG - 1), cn_expect(row_a, j, 0)});
                        exp_q1.push_back({(j == DEG - 1), cn_expect(row_a, j, OFF1)});
                    end
                    row_q.delete();
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_valid0", if0.out_valid, 1'b0);
        chk("rst_async_ready0", if0.in_ready, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_out_valid0", if0.out_valid, 1'b0);
        chk("rst_out_valid1", if1.out_valid, 1'b0);
        chk("rst_in_ready0", if0.in_ready, 1'b1);
        chk("rst_in_ready1", if1.in_ready, 1'b1);
        chk("rst_out_msg0", if0.out_msg, 16'h0000);
        chk("rst_out_last0", if0.out_last, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [W-1:0] v [DEG], input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            int cyc;
            bit acc;
            cyc    = 0;
            acc    = 1'b0;
            in_msg = v[k];
            while (!acc && cyc < 50) begin
                in_valid = 1'b1;
                acc      = if0.in_ready;
                @(posedge clk);
                #1;
                cyc++;
            end
            chk("in_accept", acc, 1'b1);
            if (gaps) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int stall_at, input int stall_len, input bit hold_in, input int max_beats);
        int beats = 0;
        int stalled = 0;
        int cyc = 0;
        while (exp_q0.size() != 0 && beats < max_beats && cyc < 200) begin
            out_ready = !(beats == stall_at && stalled < stall_len);
            if (hold_in) begin
                in_msg   = 16'h7777;
                in_valid = !(if0.out_valid && if0.out_last && out_ready);
            end
            if (if0.out_valid) begin
                if (out_ready) beats++;
                else stalled++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_row(input string name, input int start, input logic [W-1:0] e0 [DEG],
                             input logic [W-1:0] e1 [DEG]);
        logic [W:0] e;
        chk({name, "_count0"}, cap0.size() - start, DEG);
        chk({name, "_count1"}, cap1.size() - start, DEG);
        if (cap0.size() >= start + DEG && cap1.size() >= start + DEG) begin
            for (int j = 0; j < DEG; j++) begin
                e = {(j == DEG - 1), e0[j]};
                chk($sformatf("%s_o0_%0d", name, j), cap0[start + j], e);
                e = {(j == DEG - 1), e1[j]};
                chk($sformatf("%s_o1_%0d", name, j), cap1[start + j], e);
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int s;
        @(posedge clk);
        #1;
        do_reset();

        // Nominal row, both offsets; first output one cycle after last input.
        s = cap0.size();
        send_row(ROW1, DEG, 1'b0);
        chk("latency_valid0", if0.out_valid, 1'b1);
        chk("latency_msg0", if0.out_msg, 16'h0080);
        drain(-1, 0, 1'b0, 99);
        chk("drain_s1", exp_q0.size(), 0);
        check_row("s1", s, E1_0, E1_1);

        // Offset clamping to zero.
        s = cap0.size();
        send_row(ROW2, DEG, 1'b0);
        drain(-1, 0, 1'b0, 99);
        check_row("s2", s, E2_0, E2_1);

        // Saturation and ties.
        s = cap0.size();
        send_row(ROWS, DEG, 1'b0);
        drain(-1, 0, 1'b0, 99);
        check_row("sat", s, ES_0, ES_1);
        s = cap0.size();
        send_row(ROWT, DEG, 1'b0);
        drain(-1, 0, 1'b0, 99);
        check_row("tie", s, ET_0, ET_1);

        // Input gaps.
        s = cap0.size();
        send_row(ROW1, DEG, 1'b1);
        drain(-1, 0, 1'b0, 99);
        check_row("gaps", s, E1_0, E1_1);

        // Output stall at the second beat.
        s = cap0.size();
        send_row(ROW1, DEG, 1'b0);
        drain(1, 3, 1'b0, 99);
        chk("drain_stall", exp_q0.size(), 0);
        check_row("stall", s, E1_0, E1_1);

        // in_valid held through EMIT, then a back-to-back row.
        s = cap0.size();
        send_row(ROW1, DEG, 1'b0);
        drain(-1, 0, 1'b1, 99);
        chk("in_ready_after_last", if0.in_ready, 1'b1);
        check_row("hold", s, E1_0, E1_1);
        s = cap0.size();
        send_row(ROWT, DEG, 1'b0);
        drain(-1, 0, 1'b0, 99);
        check_row("b2b", s, ET_0, ET_1);

        // Reset after three inputs, then a clean row.
        send_row(ROW1, 3, 1'b0);
        do_reset();
        s = cap0.size();
        send_row(ROW1, DEG, 1'b0);
        drain(-1, 0, 1'b0, 99);
        check_row("rst_accum", s, E1_0, E1_1);

        // Reset during the fourth output beat: the rest never appears.
        s = cap0.size();
        send_row(ROW1, DEG, 1'b0);
        drain(-1, 0, 1'b0, 3);
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        chk("rst_emit_beats", cap0.size() - s, 3);
        if (cap0.size() >= s + 3) begin
            for (int j = 0; j < 3; j++) chk($sformatf("rst_emit_o0_%0d", j), cap0[s + j], {1'b0, E1_0[j]});
        end
        s = cap0.size();
        send_row(ROWT, DEG, 1'b0);
        drain(-1, 0, 1'b0, 99);
        check_row("recover", s, ET_0, ET_1);

        chk("final_queue_empty", exp_q0.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
